// File: rtl/ecc_operand_loader.sv
// Deserializes the nibble-wide operand pin stream into full-width ECC operands
// and holds each checked set for the point-multiplication core under valid/ready.
module ecc_operand_loader #(
    parameter int SIZE = 32,
    parameter int NIB  = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [NIB-1:0]  a,
    input  logic [NIB-1:0]  prime,
    input  logic [NIB-1:0]  k,
    input  logic [NIB-1:0]  Px,
    input  logic [NIB-1:0]  Py,
    output logic [SIZE-1:0] o_a,
    output logic [SIZE-1:0] o_prime,
    output logic [SIZE-1:0] o_k,
    output logic [SIZE-1:0] o_px,
    output logic [SIZE-1:0] o_py,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_err,
    output logic            o_drop,
    output logic            o_busy
);

    localparam int NBEAT = SIZE / NIB;
    localparam int CNT_W = $clog2(NBEAT);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             last_beat;
    logic             first_beat;
    logic             next_beat;
    logic             set_err;
    logic [SIZE-1:0]  full_a;
    logic [SIZE-1:0]  full_prime;
    logic [SIZE-1:0]  full_k;
    logic [SIZE-1:0]  full_px;
    logic [SIZE-1:0]  full_py;

    // The final beat lands in the top nibble, so validity is judged on the
    // registered lower beats joined with the nibble arriving this cycle.
    assign full_a     = {a,     o_a[SIZE-NIB-1:0]};
    assign full_prime = {prime, o_prime[SIZE-NIB-1:0]};
    assign full_k     = {k,     o_k[SIZE-NIB-1:0]};
    assign full_px    = {Px,    o_px[SIZE-NIB-1:0]};
    assign full_py    = {Py,    o_py[SIZE-NIB-1:0]};

    assign last_beat = (cnt == CNT_W'(NBEAT - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        first_beat = 1'b0;
        next_beat  = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE:    first_beat = i_start;
            LOAD: begin
                first_beat = i_start;
                next_beat  = !i_start;
            end
            HOLD:    first_beat = i_start && i_ready;
            default: first_beat = 1'b0;
        endcase
        set_err = !full_prime[0]
               || (full_prime < SIZE'(3))
               || (full_px >= full_prime)
               || (full_py >= full_prime)
               || (full_a  >= full_prime)
               || (full_k  == '0);
    end

    // Operand shift registers: beat 0 clears the stale upper bits of the previous set.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_a     <= '0;
            o_prime <= '0;
            o_k     <= '0;
            o_px    <= '0;
            o_py    <= '0;
        end else if (first_beat) begin
            o_a     <= SIZE'(a);
            o_prime <= SIZE'(prime);
            o_k     <= SIZE'(k);
            o_px    <= SIZE'(Px);
            o_py    <= SIZE'(Py);
        end else if (next_beat) begin
            o_a[cnt*NIB +: NIB]     <= a;
            o_prime[cnt*NIB +: NIB] <= prime;
            o_k[cnt*NIB +: NIB]     <= k;
            o_px[cnt*NIB +: NIB]    <= Px;
            o_py[cnt*NIB +: NIB]    <= Py;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            o_drop  <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            o_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        cnt    <= CNT_W'(1);
                        state  <= LOAD;
                        o_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    if (i_start) begin
                        cnt <= CNT_W'(1);
                    end else if (last_beat) begin
                        cnt     <= '0;
                        state   <= HOLD;
                        o_valid <= 1'b1;
                        o_err   <= set_err;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_err   <= 1'b0;
                        if (i_start) begin
                            cnt   <= CNT_W'(1);
                            state <= LOAD;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else if (i_start) begin
                        o_drop <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    o_valid <= 1'b0;
                    o_err   <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ecc_operand_loader.md
# ecc_operand_loader

Input stage in front of the ECC point-multiplication core. It deserializes the 4-bit nibble stream arriving on the chip pins (curve coefficient a, prime, scalar k, base point Px/Py) into full-width operand registers. It sanity-checks the operands and presents them to the core with a valid/ready handshake. The block sits between the CHIP pads and the scalar-multiply engine whose serialized kPx/kPy result the top-level bench checks.

## Interface
- SIZE, 32, operand width in bits; must be a multiple of 4.
- NIB, 4, pin-bus width per cycle; the number of beats NBEAT = SIZE/NIB (8 by default).
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  asynchronous, active-low reset; one clock; polarity and synchronicity are fixed.
- i_start  in  1  first beat of a new operand set.
- a, prime, k, Px, Py  in  NIB each  operand nibbles, least-significant nibble first.
- o_a, o_prime, o_k, o_px, o_py  out  SIZE each  assembled operands; stable while o_valid=1.
- o_valid  out  1  operand set is held for the core.
- i_ready  in  1  core accepts the set.
- o_err  out  1  the held set is invalid; qualified by o_valid.
- o_drop  out  1  one-cycle pulse when i_start is ignored.
- o_busy  out  1  the block is in LOAD or HOLD.

## Operation
- States: IDLE, LOAD, HOLD. The beat counter cnt is 3 bits wide (log2 NBEAT).
- IDLE:
  - On i_start=1, capture beat 0 into bits [3:0] of every shift register.
  - Set cnt=1 and go to LOAD.
- LOAD, per cycle:
  - Capture beat cnt into bits [4*cnt+3 : 4*cnt] and increment cnt.
  - When cnt == NBEAT-1 is captured, go to HOLD.
- LOAD, when i_start=1 mid-load: abandon the partial set, capture the current beat as beat 0, set cnt=1 and stay in LOAD. o_drop is not pulsed.
- HOLD:
  - o_valid=1 and the operands are frozen.
  - On o_valid & i_ready, the transfer completes and the block goes to IDLE.
  - If i_start=1 in the same cycle as the transfer, take beat 0 and go directly to LOAD (back-to-back, no bubble).
- HOLD, when i_start=1 without i_ready: the start is ignored, o_drop=1 for that cycle, and the state stays HOLD.
- o_err is registered together with the transition into HOLD. It is 1 if any of the following holds:
  - prime[0]==0 (even prime);
  - prime < 3;
  - Px >= prime;
  - Py >= prime;
  - a >= prime;
  - k == 0.
- All comparisons are unsigned at full SIZE width.
- The core must still handshake an errored set; the loader does not discard it.
- Nibble inputs are don't-care in IDLE unless i_start=1.

## Timing
- Reset (asynchronous, i_rst=0): state=IDLE, cnt=0, all o_* operands=0, o_valid=0, o_err=0, o_drop=0, o_busy=0.
- Cycle 0 is the cycle i_start is sampled. Beats are sampled on cycles 0..NBEAT-1, and o_valid rises after the edge that samples beat NBEAT-1.
  - Latency is NBEAT cycles from the start edge to o_valid (8 by default).
- o_busy=1 from the edge after cycle 0 through the handshake edge.
- o_valid falls on the edge that completes the handshake. The minimum start-to-start period is NBEAT cycles with i_ready held high.
- All outputs are registered; there is no combinational path from i_ready to o_valid.
- Reset asserted mid-LOAD or mid-HOLD clears the block immediately. The partial set is lost, and the first start after i_rst=1 begins cleanly.

## Test plan
- Load sequence:
  - Stimulus: with i_ready=1, pulse i_start with prime nibbles 7,0,0,0,0,0,0,0 (prime=7), a=2, k=3, Px=1, Py=6 over 8 beats.
  - Required: o_valid=1 in cycle 8 with o_prime=32'h7, o_k=32'h3, o_px=1, o_py=6, o_err=0; o_valid=0 in cycle 9.
- Nibble order: prime nibbles 1,2,3,4,5,6,7,8 produce o_prime=32'h87654321, and o_err=0 (odd).
- Invalid operands:
  - prime=32'h10 gives o_err=1 (even).
  - prime=7 with Px=9 gives o_err=1.
  - k=0 gives o_err=1.
- Back-pressure:
  - Hold i_ready=0 for 20 cycles after o_valid; the operands stay stable.
  - An i_start in that window makes o_drop pulse exactly 1 cycle, with no change to the held set.
  - Raising i_ready then gives one transfer.
- Restart and back-to-back:
  - An i_start at beat 4 of a load causes the final set to reflect only the second stream, with o_valid 8 cycles after the second start.
  - An i_start coincident with the handshake produces the next o_valid exactly 8 cycles later.
- Asynchronous reset: drive i_rst=0 mid-cycle during beat 5. All outputs go to 0 immediately, without waiting for a clock edge, and a subsequent full load passes.
